// File: rtl/meter_cmd_if.sv
// Command handshake between the pushbutton arbiter and the time-count datapath.
// The master offers a command (add or load plus a seconds value). The slave
// accepts it by asserting cmd_ready while cmd_valid is high.
interface meter_cmd_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_load;
  logic [13:0] cmd_secs;
  logic [2:0]  cmd_src;

  modport master (
    output cmd_valid,
    output cmd_load,
    output cmd_secs,
    output cmd_src,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_load,
    input  cmd_secs,
    input  cmd_src,
    output cmd_ready
  );
endinterface

// File: rtl/meter_cmd_arbiter.sv
// Parking-meter pushbutton arbiter.
// The arbiter detects rising edges on six pre-synchronized button levels and
// keeps each one as a pending request. It issues one command at a time to the
// time datapath over a valid/ready handshake.
// Priority, from highest: rst2, rst1, add4, add3, add2, add1.
// A granted load request (rst1/rst2) flushes every other pending request.
module meter_cmd_arbiter #(
  parameter int unsigned ADD1_SEC = 60,
  parameter int unsigned ADD2_SEC = 120,
  parameter int unsigned ADD3_SEC = 180,
  parameter int unsigned ADD4_SEC = 300,
  parameter int unsigned RST1_SEC = 15,
  parameter int unsigned RST2_SEC = 150
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              add1,
  input  logic              add2,
  input  logic              add3,
  input  logic              add4,
  input  logic              rst1,
  input  logic              rst2,
  meter_cmd_if.master       cmd,
  output logic [5:0]        pend,
  output logic [7:0]        drop_cnt
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  prev_q;
  logic [5:0]  pend_q, pend_d;
  logic [7:0]  drop_q, drop_d;
  logic [2:0]  src_q, src_d;
  logic        load_q, load_d;
  logic [13:0] secs_q, secs_d;

  logic [5:0]  btn;
  logic [5:0]  rise;
  logic [5:0]  gnt_oh;
  logic [5:0]  flush;
  logic [5:0]  cleared;
  logic [2:0]  pick;
  logic        grant;

  // Bit order matches pend: {rst2, rst1, add4, add3, add2, add1}.
  assign btn  = {rst2, rst1, add4, add3, add2, add1};
  assign rise = btn & ~prev_q;

  // Select the highest-priority pending source. Higher bit index wins.
  function automatic logic [2:0] prio_pick(input logic [5:0] p);
    if (p[5])      return 3'd5;
    else if (p[4]) return 3'd4;
    else if (p[3]) return 3'd3;
    else if (p[2]) return 3'd2;
    else if (p[1]) return 3'd1;
    else           return 3'd0;
  endfunction

  // Seconds value associated with each source.
  function automatic logic [13:0] secs_of(input logic [2:0] src);
    case (src)
      3'd0:    return 14'(ADD1_SEC);
      3'd1:    return 14'(ADD2_SEC);
      3'd2:    return 14'(ADD3_SEC);
      3'd3:    return 14'(ADD4_SEC);
      3'd4:    return 14'(RST1_SEC);
      3'd5:    return 14'(RST2_SEC);
      default: return 14'd0;
    endcase
  endfunction

  function automatic logic [3:0] popcount6(input logic [5:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 6; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

  // The drop counter saturates at 255 and does not wrap.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {5'd0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, grant selection, pending-set update and drop accounting.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    load_d  = load_q;
    secs_d  = secs_q;
    grant   = 1'b0;
    gnt_oh  = 6'd0;
    flush   = 6'd0;
    pick    = prio_pick(pend_q);

    case (state_q)
      S_IDLE: begin
        if (pend_q != 6'd0) begin
          grant   = 1'b1;
          state_d = S_OFFER;
        end
      end
      S_OFFER: begin
        if (cmd.cmd_ready) begin
          if (pend_q != 6'd0) grant   = 1'b1;
          else                state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (grant) begin
      gnt_oh = 6'd1 << pick;
      src_d  = pick;
      load_d = (pick == 3'd4) || (pick == 3'd5);
      secs_d = secs_of(pick);
      if (load_d) flush = pend_q & ~gnt_oh;
    end

    // A new edge always wins over a grant or a flush in the same cycle.
    cleared = gnt_oh | flush;
    pend_d  = (pend_q & ~cleared) | rise;
    // Count two kinds of drop: edges merged into a request that stays
    // pending, and requests flushed without a new edge replacing them.
    drop_d  = sat_add8(drop_q,
                       popcount6(rise & pend_q & ~cleared) + popcount6(flush & ~rise));
  end

  // Button history, pending requests, drop counter and output command register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 6'd0;
      pend_q <= 6'd0;
      drop_q <= 8'd0;
      src_q  <= 3'd0;
      load_q <= 1'b0;
      secs_q <= 14'd0;
    end else begin
      prev_q <= btn;
      pend_q <= pend_d;
      drop_q <= drop_d;
      src_q  <= src_d;
      load_q <= load_d;
      secs_q <= secs_d;
    end
  end

  assign cmd.cmd_valid = (state_q == S_OFFER);
  assign cmd.cmd_load  = load_q;
  assign cmd.cmd_secs  = secs_q;
  assign cmd.cmd_src   = src_q;
  assign pend          = pend_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_meter_cmd_arbiter.sv
// Directed testbench for meter_cmd_arbiter.
module tb_meter_cmd_arbiter;

  logic       clk;
  logic       rst;
  logic       add1, add2, add3, add4, rst1, rst2;
  logic [5:0] pend;
  logic [7:0] drop_cnt;
  int         n_tests;
  int         n_fail;

  meter_cmd_if bus ();

  meter_cmd_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .add1     (add1),
    .add2     (add2),
    .add3     (add3),
    .add4     (add4),
    .rst1     (rst1),
    .rst2     (rst2),
    .cmd      (bus),
    .pend     (pend),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    add1 = 0; add2 = 0; add3 = 0; add4 = 0; rst1 = 0; rst2 = 0;
    bus.cmd_ready = 1'b0;
    tick(); tick();
    n_tests++; if (bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", bus.cmd_valid); end
    n_tests++; if ({bus.cmd_load, bus.cmd_secs, bus.cmd_src} !== 18'd0) begin n_fail++; $display("FAIL reset_cmd: got load=%0b secs=%0d src=%0d want 0", bus.cmd_load, bus.cmd_secs, bus.cmd_src); end
    n_tests++; if (pend !== 6'd0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_pend_drop: got pend=%b drop=%0d want 0/0", pend, drop_cnt); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bus.cmd_ready = 1'b1;
    add1 = 1'b1; tick(); add1 = 1'b0;
    n_tests++; if (pend !== 6'b000001 || bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pend: got pend=%b valid=%0b want 000001/0", pend, bus.cmd_valid); end
    tick();
    n_tests++; if (bus.cmd_valid !== 1'b1 || bus.cmd_src !== 3'd0 || bus.cmd_load !== 1'b0 || bus.cmd_secs !== 14'd60) begin n_fail++; $display("FAIL basic_offer: got v=%0b src=%0d load=%0b secs=%0d want 1/0/0/60", bus.cmd_valid, bus.cmd_src, bus.cmd_load, bus.cmd_secs); end
    n_tests++; if (pend !== 6'd0) begin n_fail++; $display("FAIL basic_pend_clear: got %b want 000000", pend); end
    tick();
    n_tests++; if (bus.cmd_valid !== 1'b0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL basic_done: got valid=%0b drop=%0d want 0/0", bus.cmd_valid, drop_cnt); end
  endtask

  task automatic test_priority();
    bus.cmd_ready = 1'b0;
    add2 = 1'b1; add4 = 1'b1; tick(); add2 = 1'b0; add4 = 1'b0;
    tick();
    n_tests++; if (bus.cmd_valid !== 1'b1 || bus.cmd_src !== 3'd3 || bus.cmd_secs !== 14'd300 || pend !== 6'b000010) begin n_fail++; $display("FAIL prio_first: got v=%0b src=%0d secs=%0d pend=%b want 1/3/300/000010", bus.cmd_valid, bus.cmd_src, bus.cmd_secs, pend); end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++; if (bus.cmd_valid !== 1'b1 || bus.cmd_src !== 3'd3 || bus.cmd_secs !== 14'd300) begin n_fail++; $display("FAIL prio_hold[%0d]: got v=%0b src=%0d secs=%0d want 1/3/300", i, bus.cmd_valid, bus.cmd_src, bus.cmd_secs); end
    end
    bus.cmd_ready = 1'b1;
    tick();
    n_tests++; if (bus.cmd_valid !== 1'b1 || bus.cmd_src !== 3'd1 || bus.cmd_secs !== 14'd120 || bus.cmd_load !== 1'b0) begin n_fail++; $display("FAIL prio_b2b: got v=%0b src=%0d secs=%0d load=%0b want 1/1/120/0", bus.cmd_valid, bus.cmd_src, bus.cmd_secs, bus.cmd_load); end
    tick();
    n_tests++; if (bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL prio_end: got valid=%0b want 0", bus.cmd_valid); end
  endtask

  task automatic test_coalesce();
    bus.cmd_ready = 1'b0;
    add1 = 1'b1; tick(); add1 = 1'b0; tick();
    n_tests++; if (bus.cmd_valid !== 1'b1 || bus.cmd_src !== 3'd0) begin n_fail++; $display("FAIL coal_offer: got v=%0b src=%0d want 1/0", bus.cmd_valid, bus.cmd_src); end
    for (int i = 0; i < 3; i++) begin
      add3 = 1'b1; tick(); add3 = 1'b0; tick();
    end
    n_tests++; if (pend !== 6'b000100 || drop_cnt !== 8'd2) begin n_fail++; $display("FAIL coal_state: got pend=%b drop=%0d want 000100/2", pend, drop_cnt); end
    bus.cmd_ready = 1'b1;
    tick();
    n_tests++; if (bus.cmd_valid !== 1'b1 || bus.cmd_src !== 3'd2 || bus.cmd_secs !== 14'd180) begin n_fail++; $display("FAIL coal_issue: got v=%0b src=%0d secs=%0d want 1/2/180", bus.cmd_valid, bus.cmd_src, bus.cmd_secs); end
    tick();
    n_tests++; if (bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL coal_end: got valid=%0b want 0", bus.cmd_valid); end
    tick(); tick();
    n_tests++; if (bus.cmd_valid !== 1'b0 || pend !== 6'd0) begin n_fail++; $display("FAIL coal_single: got valid=%0b pend=%b want 0/000000", bus.cmd_valid, pend); end
  endtask

  task automatic test_load_flush();
    bus.cmd_ready = 1'b0;
    add4 = 1'b1; tick(); add4 = 1'b0; tick();
    n_tests++; if (bus.cmd_valid !== 1'b1 || bus.cmd_src !== 3'd3) begin n_fail++; $display("FAIL flush_pre: got v=%0b src=%0d want 1/3", bus.cmd_valid, bus.cmd_src); end
    add1 = 1'b1; tick(); add1 = 1'b0;
    add2 = 1'b1; tick(); add2 = 1'b0;
    rst1 = 1'b1; tick(); rst1 = 1'b0;
    n_tests++; if (pend !== 6'b010011) begin n_fail++; $display("FAIL flush_pend: got %b want 010011", pend); end
    bus.cmd_ready = 1'b1;
    tick();
    n_tests++; if (bus.cmd_valid !== 1'b1 || bus.cmd_src !== 3'd4 || bus.cmd_load !== 1'b1 || bus.cmd_secs !== 14'd15) begin n_fail++; $display("FAIL flush_load: got v=%0b src=%0d load=%0b secs=%0d want 1/4/1/15", bus.cmd_valid, bus.cmd_src, bus.cmd_load, bus.cmd_secs); end
    n_tests++; if (pend !== 6'd0 || drop_cnt !== 8'd4) begin n_fail++; $display("FAIL flush_drop: got pend=%b drop=%0d want 000000/4", pend, drop_cnt); end
    tick();
    n_tests++; if (bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL flush_end: got valid=%0b want 0", bus.cmd_valid); end
  endtask

  task automatic test_rst_pair();
    bus.cmd_ready = 1'b0;
    rst1 = 1'b1; rst2 = 1'b1; tick(); rst1 = 1'b0; rst2 = 1'b0;
    tick();
    n_tests++; if (bus.cmd_valid !== 1'b1 || bus.cmd_src !== 3'd5 || bus.cmd_load !== 1'b1 || bus.cmd_secs !== 14'd150) begin n_fail++; $display("FAIL pair_offer: got v=%0b src=%0d load=%0b secs=%0d want 1/5/1/150", bus.cmd_valid, bus.cmd_src, bus.cmd_load, bus.cmd_secs); end
    n_tests++; if (pend !== 6'd0 || drop_cnt !== 8'd5) begin n_fail++; $display("FAIL pair_drop: got pend=%b drop=%0d want 000000/5", pend, drop_cnt); end
    bus.cmd_ready = 1'b1;
    tick();
    n_tests++; if (bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL pair_end: got valid=%0b want 0", bus.cmd_valid); end
  endtask

  task automatic test_same_cycle();
    bus.cmd_ready = 1'b0;
    add4 = 1'b1; tick(); add4 = 1'b0; tick();
    add3 = 1'b1; tick(); add3 = 1'b0; tick();
    n_tests++; if (bus.cmd_src !== 3'd3 || pend !== 6'b000100) begin n_fail++; $display("FAIL same_pre: got src=%0d pend=%b want 3/000100", bus.cmd_src, pend); end
    bus.cmd_ready = 1'b1; add3 = 1'b1;
    tick(); add3 = 1'b0;
    n_tests++; if (bus.cmd_valid !== 1'b1 || bus.cmd_src !== 3'd2 || pend !== 6'b000100 || drop_cnt !== 8'd5) begin n_fail++; $display("FAIL same_grant: got v=%0b src=%0d pend=%b drop=%0d want 1/2/000100/5", bus.cmd_valid, bus.cmd_src, pend, drop_cnt); end
    tick();
    n_tests++; if (bus.cmd_valid !== 1'b1 || bus.cmd_src !== 3'd2 || pend !== 6'd0) begin n_fail++; $display("FAIL same_second: got v=%0b src=%0d pend=%b want 1/2/000000", bus.cmd_valid, bus.cmd_src, pend); end
    tick();
    n_tests++; if (bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL same_end: got valid=%0b want 0", bus.cmd_valid); end
  endtask

  task automatic test_drop_saturation();
    bus.cmd_ready = 1'b0;
    add1 = 1'b1; tick(); add1 = 1'b0; tick();
    for (int i = 0; i < 260; i++) begin
      add1 = 1'b1; tick(); add1 = 1'b0; tick();
    end
    n_tests++; if (drop_cnt !== 8'd255 || pend !== 6'b000001 || bus.cmd_valid !== 1'b1) begin n_fail++; $display("FAIL sat_drop: got drop=%0d pend=%b valid=%0b want 255/000001/1", drop_cnt, pend, bus.cmd_valid); end
  endtask

  task automatic test_async_reset();
    int seen;
    add2 = 1'b1; tick(); add2 = 1'b0;
    n_tests++; if (pend !== 6'b000011 || bus.cmd_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre: got pend=%b valid=%0b want 000011/1", pend, bus.cmd_valid); end
    add3 = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_tests++; if (bus.cmd_valid !== 1'b0 || bus.cmd_load !== 1'b0 || bus.cmd_secs !== 14'd0 || bus.cmd_src !== 3'd0) begin n_fail++; $display("FAIL areset_cmd: got v=%0b load=%0b secs=%0d src=%0d want 0/0/0/0", bus.cmd_valid, bus.cmd_load, bus.cmd_secs, bus.cmd_src); end
    n_tests++; if (pend !== 6'd0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL areset_state: got pend=%b drop=%0d want 000000/0", pend, drop_cnt); end
    tick(); tick();
    rst = 1'b0;
    bus.cmd_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.cmd_valid === 1'b1) begin
        seen++;
        n_tests++; if (bus.cmd_src !== 3'd2 || bus.cmd_secs !== 14'd180) begin n_fail++; $display("FAIL areset_held_cmd: got src=%0d secs=%0d want 2/180", bus.cmd_src, bus.cmd_secs); end
      end
    end
    n_tests++; if (seen !== 1) begin n_fail++; $display("FAIL areset_held_count: got %0d commands want 1", seen); end
    n_tests++; if (pend !== 6'd0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL areset_after: got pend=%b drop=%0d want 000000/0", pend, drop_cnt); end
    add3 = 1'b0;
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    add1 = 0; add2 = 0; add3 = 0; add4 = 0; rst1 = 0; rst2 = 0;
    bus.cmd_ready = 1'b0;
    test_reset();
    test_basic();
    test_priority();
    test_coalesce();
    test_load_flush();
    test_rst_pair();
    test_same_cycle();
    test_drop_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/meter_cmd_arbiter.md
Name: meter_cmd_arbiter

Overview:
- Sits between the six parking-meter pushbutton inputs (add1..add4, rst1, rst2) and the meter's time-count datapath.
- Edge-detects each button and holds pending requests.
- Resolves simultaneous presses by fixed priority and issues one command at a time over a valid/ready handshake with the associated seconds value.
- The time datapath asserts ready only when it can accept an update, e.g. not during its 1 Hz decrement cycle.

Parameters:
- ADD1_SEC, 60, seconds added by add1
- ADD2_SEC, 120, seconds added by add2
- ADD3_SEC, 180, seconds added by add3
- ADD4_SEC, 300, seconds added by add4
- RST1_SEC, 15, seconds loaded by rst1
- RST2_SEC, 150, seconds loaded by rst2

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- add1  in  1  button level (pre-synchronized); rising edge = request
- add2  in  1  as add1
- add3  in  1  as add1
- add4  in  1  as add1
- rst1  in  1  as add1; load request
- rst2  in  1  as add1; load request
- cmd_ready  in  1  datapath can accept a command this cycle
- cmd_valid  out  1  command offered
- cmd_load  out  1  1 = load cmd_secs (rst1/rst2), 0 = add cmd_secs
- cmd_secs  out  14  seconds value for the command
- cmd_src  out  3  source: 0 add1, 1 add2, 2 add3, 3 add4, 4 rst1, 5 rst2
- pend  out  6  pending bits {rst2,rst1,add4,add3,add2,add1}
- drop_cnt  out  8  saturating count of coalesced or flushed requests

Behaviour:
- Reset (async, any time, including mid-offer):
  - all outputs 0 (cmd_valid=0, cmd_load=0, cmd_secs=0, cmd_src=0, pend=0, drop_cnt=0)
  - previous-level registers cleared to 0, so a button held high through reset release produces one request.
- Edge detect:
  - a request fires in the cycle where the level is 1 and the registered previous level is 0.
  - It sets the matching pend bit at the next posedge.
- Coalesce:
  - an edge on a bit already pending (and not being granted that cycle) is merged; drop_cnt += 1.
- Two-state FSM, IDLE and OFFER.
  - IDLE: if pend != 0, load the output register with the highest-priority pending bit, clear that bit, and go to OFFER (cmd_valid=1 next cycle). Latency is 2 cycles from button edge to cmd_valid.
  - OFFER: cmd_valid, cmd_load, cmd_secs and cmd_src are held stable until the transfer (cmd_valid & cmd_ready at posedge).
  - On transfer, if pend != 0, grant the next request in the same edge: back-to-back, with cmd_valid staying 1. Otherwise go to IDLE.
- Priority: rst2 > rst1 > add4 > add3 > add2 > add1.
- Load flush: when rst1 or rst2 is granted, all other pend bits are cleared, including the lower-priority rst1.
  - drop_cnt += number of bits flushed.
- Same-cycle set and clear: an edge arriving in the cycle its bit is granted or flushed wins. The bit stays or becomes pending and no drop is counted.
- An edge on the source currently held in the output register (not pending) is a new, separate request; no drop.
- drop_cnt saturates at 255 and is never cleared except by rst.
- cmd_secs is the zero-extended parameter for cmd_src; cmd_load=1 only for src 4 and 5.

Test Plan:
- rst high 2 cycles then low. Pulse add1 for 1 cycle with cmd_ready=1. Required: cmd_valid=1 for exactly 1 cycle, 2 cycles after the edge, with cmd_src=0, cmd_load=0, cmd_secs=60. pend returns to 0 and drop_cnt=0.
- cmd_ready=0; pulse add2 and add4 in the same cycle. Required: the offer is src=3, secs=300, held for 10 cycles. Raise ready: src=3 transfers, then src=1/120 is offered in the next cycle with valid continuously 1, then valid drops.
- cmd_ready=0 while offering; pulse add3 three times. Required: pend[2]=1 and drop_cnt=2. After ready, exactly one add3 (180) command is issued.
- cmd_ready=0; pulse add1, add2, then rst1. Required: rst1 is granted next (load=1, secs=15). pend clears and drop_cnt increases by 2. Only the load command is seen.
- Pulse rst1 and rst2 together. Required: src=5, load=1, secs=150; rst1 is flushed and drop_cnt += 1.
- While cmd_valid=1 with pend=3'b011 bits set, assert rst asynchronously mid-cycle. Required: all outputs are 0 immediately without waiting for a clock edge. A button held high across reset release yields exactly one request.
